// File: rtl/timer.sv
// Memory-mapped cycle timer: free-running counter, compare register and a
// level-held interrupt request that stays up until software acknowledges it.
module timer #(
  parameter int                 width      = 64,
  parameter logic [width-1:0]   CYCLE_ADDR = 64'hffff001c,
  parameter logic [width-1:0]   ACK_ADDR   = 64'hffff006c
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [width-1:0] address,
  input  logic [width-1:0] data,
  input  logic             MemRead,
  input  logic             MemWrite,
  output logic [width-1:0] cycle,
  output logic             TimerAddress,
  output logic             TimerInterrupt
);

  localparam logic [width-1:0] one = {{(width-1){1'b0}}, 1'b1};

  logic [width-1:0] cycle_counter;
  logic [width-1:0] interrupt_cycle;
  logic             interrupt_line;

  logic sel_cycle;
  logic sel_ack;
  logic match;
  logic ack;

  // Address decode, compare and load-data steering are purely combinational.
  always_comb begin
    sel_cycle    = (address == CYCLE_ADDR);
    sel_ack      = (address == ACK_ADDR);
    TimerAddress = sel_cycle | sel_ack;
    match        = (cycle_counter == interrupt_cycle);
    ack          = MemWrite & sel_ack;
    cycle        = (MemRead && sel_cycle) ? cycle_counter : '0;
  end

  // Counter, compare register and interrupt line; a match beats a
  // same-cycle ack so a fresh event is never dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_counter   <= '0;
      interrupt_cycle <= '1;
      interrupt_line  <= 1'b0;
    end else begin
      cycle_counter <= cycle_counter + one;
      if (MemWrite && sel_cycle)
        interrupt_cycle <= data;
      if (match)
        interrupt_line <= 1'b1;
      else if (ack)
        interrupt_line <= 1'b0;
    end
  end

  assign TimerInterrupt = interrupt_line;

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for timer: directed scenarios with fixed expectations
// followed by random bus traffic compared against a cycle-level model.
module tb_timer;

  localparam logic [63:0] CA  = 64'hffff001c;
  localparam logic [63:0] ACK = 64'hffff006c;

  logic        clock;
  logic        reset;
  logic [63:0] address;
  logic [63:0] data;
  logic        MemRead;
  logic        MemWrite;
  logic [63:0] cycle;
  logic        TimerAddress;
  logic        TimerInterrupt;

  timer dut (
    .clock(clock), .reset(reset), .address(address), .data(data),
    .MemRead(MemRead), .MemWrite(MemWrite), .cycle(cycle),
    .TimerAddress(TimerAddress), .TimerInterrupt(TimerInterrupt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: elapsed cycles since reset, armed compare, pending flag
  logic [63:0] m_cnt;
  logic [63:0] m_cmp;
  bit          m_line;
  bit          m_valid = 0;

  logic [63:0] obs_cycle;
  logic        obs_ta;
  logic        obs_int;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One bus cycle: drive, observe mid-cycle, then let the edge happen and
  // advance the model.
  task automatic step(input bit rst, input bit rd, input bit wr,
                      input logic [63:0] a, input logic [63:0] d);
    bit hit;
    reset = rst; MemRead = rd; MemWrite = wr; address = a; data = d;
    @(negedge clock);
    obs_cycle = cycle; obs_ta = TimerAddress; obs_int = TimerInterrupt;
    chk("taddr", {63'd0, obs_ta}, {63'd0, (a == CA) || (a == ACK)});
    if (m_valid) begin
      chk("load", obs_cycle, (rd && a == CA) ? m_cnt : 64'd0);
      chk("irq", {63'd0, obs_int}, {63'd0, m_line});
    end
    @(posedge clock);
    if (rst) begin
      m_cnt = 0; m_cmp = '1; m_line = 0; m_valid = 1;
    end else begin
      hit = (m_cnt == m_cmp);
      if (wr && a == CA) m_cmp = d;
      if (hit) m_line = 1;
      else if (wr && a == ACK) m_line = 0;
      m_cnt = m_cnt + 64'd1;
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 64'h0, 64'h0);
  endtask

  task automatic idle_to(input logic [63:0] target);
    for (int k = 0; k < 200 && m_cnt != target; k++) idle();
    chk("reach_cnt", m_cnt, target);
  endtask

  initial begin
    reset = 1; MemRead = 0; MemWrite = 0; address = 0; data = 0;

    step(1, 0, 0, 64'h0, 64'h0);
    step(1, 1, 1, CA, 64'h3);

    // post-reset loads read 0..4, no interrupt
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, CA, 64'h0);
      chk("ld_seq", obs_cycle, 64'(i));
      chk("no_irq_early", {63'd0, obs_int}, 64'd0);
    end
    step(0, 1, 0, ACK, 64'h0);
    chk("ld_ack_zero", obs_cycle, 64'd0);
    chk("ack_taddr", {63'd0, obs_ta}, 64'd1);
    step(0, 1, 0, 64'h1000, 64'h0);
    chk("other_taddr", {63'd0, obs_ta}, 64'd0);
    chk("other_load", obs_cycle, 64'd0);

    // arm 20 at counter 10
    idle_to(10);
    step(0, 1, 1, CA, 64'd20);
    chk("ld_at_store", obs_cycle, 64'd10);
    while (m_cnt < 21) begin
      step(0, 0, 0, 64'h0, 64'h0);
      chk("pre_match", {63'd0, obs_int}, 64'd0);
    end
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 0, 64'h0, 64'h0);
      chk("held", {63'd0, obs_int}, 64'd1);
    end
    // counter now 30: ack, then second ack
    step(0, 0, 1, ACK, 64'hdead);
    chk("pre_ack", {63'd0, obs_int}, 64'd1);
    step(0, 0, 1, ACK, 64'h0);
    chk("post_ack", {63'd0, obs_int}, 64'd0);
    idle();
    chk("post_ack2", {63'd0, obs_int}, 64'd0);

    // simultaneous ack and match with line already high
    step(0, 0, 1, CA, 64'd40);
    idle_to(41);
    idle();
    chk("armed_40", {63'd0, obs_int}, 64'd1);
    step(0, 0, 1, CA, 64'd50);
    idle_to(50);
    step(0, 0, 1, ACK, 64'h0);
    idle();
    chk("set_beats_ack", {63'd0, obs_int}, 64'd1);
    step(0, 0, 1, ACK, 64'h0);
    idle();
    chk("cleared", {63'd0, obs_int}, 64'd0);

    // compare equal to current counter never fires without wrap
    step(1, 0, 0, 64'h0, 64'h0);
    idle_to(7);
    step(0, 0, 1, CA, 64'd7);
    for (int i = 0; i < 50; i++) begin
      idle();
      chk("eq_no_fire", {63'd0, obs_int}, 64'd0);
    end
    idle_to(58);
    step(0, 0, 1, CA, 64'd60);
    idle(); idle();
    chk("fire_60_pre", {63'd0, obs_int}, 64'd0);
    idle();
    chk("fire_60", {63'd0, obs_int}, 64'd1);

    // reset with pending irq and concurrent compare store of 5
    step(1, 0, 1, CA, 64'd5);
    step(0, 1, 0, CA, 64'h0);
    chk("rst_cnt", obs_cycle, 64'd0);
    chk("rst_irq", {63'd0, obs_int}, 64'd0);
    for (int i = 0; i < 10; i++) begin
      idle();
      chk("rst_no_fire5", {63'd0, obs_int}, 64'd0);
    end

    // random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      logic [63:0] a, d;
      bit rd, wr, rst;
      case ($urandom_range(0, 3))
        0: a = CA;
        1: a = ACK;
        2: a = {$urandom, $urandom};
        default: a = 64'h1000;
      endcase
      rd  = $urandom_range(0, 1) == 1;
      wr  = $urandom_range(0, 2) == 0;
      rst = $urandom_range(0, 299) == 0;
      d   = m_cnt + 64'($urandom_range(0, 12));
      step(rst, rd, wr, a, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
